rv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the rv pipeline. It owns the fetch PC, issues word requests to instruction memory over a request/grant interface, and buffers returned instructions in a FIFO of configurable depth. Instructions go to decode under a valid/ready handshake, and EX-stage redirects flush all in-flight and buffered fetches. It replaces the fixed PC register and single IF/ID latch with a decoupled fetch path that tolerates memory latency and decode stalls.

---
 rtl/rv_pkg.sv | 21 ++
 rtl/rv_fetch_fifo.sv | 56 +++++
 rtl/rv_fetch_unit.sv | 109 ++++++++++
 tb/tb_rv_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and types for the rv fetch path
package rv_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int ILEN         = 32;

    localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

    // Default-width fetch-queue entry; parametrised users size entries with entry_width()
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN-1:0]         instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = XLEN_DEFAULT + ILEN;

    function automatic int entry_width(input int xlen);
        return xlen + ILEN;
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// rtl/rv_fetch_fifo.sv - synchronous FIFO with flush, used for fetch data and PC tags
module rv_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush discards everything including a same-cycle push/pop
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// rtl/rv_fetch_unit.sv - decoupled instruction fetch front end with redirect flush
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int EW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   dc;
    logic [CW-1:0]   os;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   tag_cnt;
    logic [XLEN-1:0] tag_pc;
    logic            tag_full;
    logic            tag_empty;
    logic            q_full;
    logic            q_empty;
    logic [EW-1:0]   q_data;
    logic            credit_ok;
    logic            issue;
    logic            keep_rsp;

    // Responses owed = live tags plus responses already marked for discard
    assign os        = dc + tag_cnt;
    assign credit_ok = ({1'b0, os} + {1'b0, cnt}) < (CW + 1)'(FQ_DEPTH);

    assign imem_req_o  = rstn && !redirect_i && credit_ok && !q_full && !tag_full;
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_gnt_i;
    assign keep_rsp    = imem_rvalid_i && (dc == '0) && !redirect_i && !tag_empty;

    assign instr_valid_o = !q_empty;
    assign instr_o       = instr_valid_o ? q_data[ILEN-1:0] : '0;
    assign pc_o          = instr_valid_o ? q_data[EW-1:ILEN] : '0;

    // Fetch PC: redirect target wins, otherwise advance one word per granted request
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // Discard counter: on redirect every response still owed becomes a discard
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dc <= '0;
        end else if (redirect_i) begin
            dc <= os - CW'(imem_rvalid_i);
        end else if (imem_rvalid_i && (dc != '0)) begin
            dc <= dc - CW'(1);
        end
    end

    rv_fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect_i),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (keep_rsp),
        .pop_data  (tag_pc),
        .count     (tag_cnt),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    rv_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect_i),
        .push      (keep_rsp),
        .push_data ({tag_pc, imem_rdata_i}),
        .pop       (instr_valid_o && instr_ready_i),
        .pop_data  (q_data),
        .count     (cnt),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb/tb_rv_fetch_unit.sv - self-checking bench for rv_fetch_unit
module tb_rv_fetch_unit;

    localparam int          XLEN   = 32;
    localparam int          FQ     = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    always #5 clk = ~clk;

    rv_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .FQ_DEPTH (FQ)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct {
        logic rstn; logic req; logic [31:0] addr;
        logic valid; logic [31:0] instr; logic [31:0] pc;
    } vec_t;

    mreq_t mq[$];
    ent_t  exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_grant  = 0;
    int lat      = 1;

    logic        ctl_rstn  = 1'b0;
    logic        ctl_gnt   = 1'b1;
    logic        ctl_ready = 1'b1;
    logic        ctl_redir = 1'b0;
    logic [31:0] ctl_rpc   = 32'h0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // One clock cycle: drive inputs and memory model, sample, update scoreboard
    task automatic step();
        ent_t e;
        @(negedge clk);
        rstn          = ctl_rstn;
        imem_gnt_i    = ctl_gnt;
        instr_ready_i = ctl_ready;
        redirect_i    = ctl_redir;
        redirect_pc_i = ctl_rpc;
        if (!ctl_rstn) begin
            mq.delete();
            exp_q.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = instr_valid_o;
        s_instr = instr_o;
        s_pc    = pc_o;
        if (ctl_rstn) begin
            if (imem_rvalid_i) void'(mq.pop_front());
            if (s_valid && instr_ready_i && !redirect_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", {s_pc, s_instr}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pop", {s_pc, s_instr}, {e.pc, e.instr});
                end
            end
            if (redirect_i) exp_q.delete();
            if (s_req && imem_gnt_i) begin
                n_grant++;
                mq.push_back('{addr: s_addr, due: cyc + lat});
                exp_q.push_back('{pc: s_addr, instr: mem_word(s_addr)});
            end
        end
        cyc++;
    endtask

    task automatic reset_dut(input int l);
        lat       = l;
        ctl_rstn  = 1'b0;
        ctl_redir = 1'b0;
        ctl_gnt   = 1'b1;
        step();
        step();
        ctl_rstn = 1'b1;
        n_grant  = 0;
    endtask

    task automatic drain(input string nm);
        int k;
        ctl_gnt   = 1'b0;
        ctl_ready = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while ((exp_q.size() != 0 || mq.size() != 0) && k < 40);
        check({nm, "_drained"}, exp_q.size(), 0);
        step();
        check({nm, "_idle"}, s_valid, 1'b0);
    endtask

    task automatic wait_first(input string nm, input logic [31:0] pc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!s_valid && k < 40);
        check(nm, {s_valid, s_pc}, {1'b1, pc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tv[6];
        tv[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,        32'h0};
        tv[1] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0,        32'h0};
        tv[2] = '{1'b1, 1'b1, 32'h4,  1'b0, 32'h0,        32'h0};
        tv[3] = '{1'b1, 1'b1, 32'h8,  1'b1, mem_word(0),  32'h0};
        tv[4] = '{1'b1, 1'b1, 32'hC,  1'b1, mem_word(4),  32'h4};
        tv[5] = '{1'b1, 1'b1, 32'h10, 1'b1, mem_word(8),  32'h8};

        rstn = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        // Reset and streaming release, 1-cycle memory
        lat = 1; ctl_rstn = 1'b0; ctl_gnt = 1'b1; ctl_ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            ctl_rstn = tv[i].rstn;
            step();
            check($sformatf("vec%0d", i), {s_req, s_addr, s_valid, s_instr, s_pc},
                  {tv[i].req, tv[i].addr, tv[i].valid, tv[i].instr, tv[i].pc});
        end
        drain("stream");

        // Decode backpressure caps outstanding plus buffered at FQ
        ctl_ready = 1'b0;
        reset_dut(1);
        for (int i = 0; i < 12; i++) step();
        check("bp_grants", n_grant, FQ);
        check("bp_hold", {s_req, s_valid, s_pc}, {1'b0, 1'b1, 32'h0});
        ctl_ready = 1'b1;
        step();
        step();
        check("bp_resume", s_req, 1'b1);
        drain("bp");

        // Latency 3, redirect with two outstanding
        ctl_ready = 1'b1;
        reset_dut(3);
        step();
        step();
        ctl_redir = 1'b1; ctl_rpc = 32'h1002;
        step();
        check("rd3_noreq", s_req, 1'b0);
        ctl_redir = 1'b0;
        step();
        check("rd3_addr", {s_req, s_addr}, {1'b1, 32'h1000});
        wait_first("rd3_first", 32'h1000);
        drain("rd3");

        // Redirect coincident with a response and an accepted pop
        reset_dut(1);
        for (int i = 0; i < 3; i++) step();
        ctl_redir = 1'b1; ctl_rpc = 32'h2000;
        step();
        check("co_setup", {s_valid, imem_rvalid_i}, 2'b11);
        ctl_redir = 1'b0;
        step();
        check("co_next", {s_valid, s_req, s_addr}, {1'b0, 1'b1, 32'h2000});
        wait_first("co_first", 32'h2000);
        drain("co");

        // Fetch PC wraps at the top of the address space
        reset_dut(1);
        ctl_redir = 1'b1; ctl_rpc = 32'hFFFF_FFFC;
        step();
        ctl_redir = 1'b0;
        step();
        check("wrap_top", {s_req, s_addr}, {1'b1, 32'hFFFF_FFFC});
        step();
        check("wrap_zero", {s_req, s_addr}, {1'b1, 32'h0});
        drain("wrap");

        // Reset pulse with three entries queued
        ctl_ready = 1'b0;
        reset_dut(1);
        for (int i = 0; i < 3; i++) step();
        ctl_gnt = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("mr_setup", {n_grant, s_valid}, {32'd3, 1'b1});
        ctl_rstn = 1'b0; ctl_gnt = 1'b1;
        step();
        check("mr_inreset", s_req, 1'b0);
        ctl_rstn = 1'b1; ctl_ready = 1'b1;
        step();
        check("mr_after", {s_valid, s_req, s_addr}, {1'b0, 1'b1, RST_PC});
        drain("mr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
